// File: rtl/dbus_ctrl_pkg.sv
// Shared types and constants for the data-bus access controller.
// Length codes, FSM states and the misalignment rule live here.
package dbus_ctrl_pkg;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;
    localparam logic [1:0] LEN_X = 2'b11;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A byte never faults; halves need an even address, words a
    // word-aligned one, and the reserved length code always faults.
    function automatic logic misaligned(
        input logic [1:0] a,
        input logic [1:0] len
    );
        return ((len == LEN_H) && a[0])
            || ((len == LEN_W) && (a != 2'b00))
            || (len == LEN_X);
    endfunction

endpackage

// File: rtl/dbus_ctrl_if.sv
// Pipeline-side and bus-side signals of the data-bus controller.
// master is the controller, slave is whatever drives it.
interface dbus_ctrl_if;

    logic        i_rd;
    logic        i_wr;
    logic [31:0] i_addr;
    logic [1:0]  i_length;
    logic [3:0]  i_we;
    logic [31:0] i_data_wr;
    logic        o_stall;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_data_rd;
    logic        o_bus_cyc;
    logic        o_bus_we;
    logic [31:0] o_bus_adr;
    logic [3:0]  o_bus_sel;
    logic [31:0] o_bus_dat_w;
    logic        i_bus_ack;
    logic        i_bus_err;
    logic [31:0] i_bus_dat_r;

    modport master (
        input  i_rd, i_wr, i_addr, i_length, i_we, i_data_wr,
        input  i_bus_ack, i_bus_err, i_bus_dat_r,
        output o_stall, o_done, o_err, o_data_rd,
        output o_bus_cyc, o_bus_we, o_bus_adr, o_bus_sel, o_bus_dat_w
    );

    modport slave (
        output i_rd, i_wr, i_addr, i_length, i_we, i_data_wr,
        output i_bus_ack, i_bus_err, i_bus_dat_r,
        input  o_stall, o_done, o_err, o_data_rd,
        input  o_bus_cyc, o_bus_we, o_bus_adr, o_bus_sel, o_bus_dat_w
    );

endinterface

// File: rtl/dbus_ctrl_bus_timeout.sv
// Cycle counter bounding how long a bus beat may wait for the slave.
// Expired once the count reaches TIMEOUT; clear has priority.
module bus_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TW-1:0] cnt;

    // count up while enabled, restart on clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign o_expired = (cnt == TW'(TIMEOUT));

endmodule

// File: rtl/dbus_ctrl.sv
// Data-bus access controller: one single-beat bus cycle per load/store,
// stalling the pipeline until the beat completes, faults or times out.
module dbus_ctrl
    import dbus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    dbus_ctrl_if.master bus
);

    state_t      state;
    state_t      state_nx;
    logic        req;
    logic        is_st;
    logic        mis;
    logic        expired;
    logic        tmo_clr;
    logic        tmo_en;
    logic        err_q;
    logic        cyc_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_w_q;
    logic [31:0] data_rd_q;

    // a simultaneous rd+wr is resolved as a store
    assign req   = bus.i_rd | bus.i_wr;
    assign is_st = bus.i_wr;
    assign mis   = misaligned(bus.i_addr[1:0], bus.i_length);

    bus_timeout #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_tmo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (tmo_clr),
        .i_en      (tmo_en),
        .o_expired (expired)
    );

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state and timeout counter control
    always_comb begin
        state_nx = state;
        tmo_clr  = 1'b0;
        tmo_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tmo_clr = 1'b1;
                if (req) begin
                    state_nx = mis ? ST_DONE : ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus.i_bus_err || bus.i_bus_ack || expired) begin
                    state_nx = ST_DONE;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // bus request registers: loaded on issue, held through the beat
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_w_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req && !mis) begin
                        cyc_q   <= 1'b1;
                        we_q    <= is_st;
                        adr_q   <= {bus.i_addr[31:2], 2'b00};
                        sel_q   <= is_st ? bus.i_we : 4'b1111;
                        dat_w_q <= bus.i_data_wr;
                    end
                end
                ST_BUS: begin
                    if (state_nx == ST_DONE) begin
                        cyc_q <= 1'b0;
                    end
                end
                default: begin
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    // error flag and read-data capture; err beats ack in the same cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q     <= 1'b0;
            data_rd_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req && mis) begin
                        err_q <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (bus.i_bus_err) begin
                        err_q <= 1'b1;
                    end else if (bus.i_bus_ack) begin
                        if (!we_q) begin
                            data_rd_q <= bus.i_bus_dat_r;
                        end
                    end else if (expired) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_stall     = ((state == ST_IDLE) && req) || (state == ST_BUS);
    assign bus.o_done      = (state == ST_DONE);
    assign bus.o_err       = (state == ST_DONE) && err_q;
    assign bus.o_data_rd   = data_rd_q;
    assign bus.o_bus_cyc   = cyc_q;
    assign bus.o_bus_we    = we_q;
    assign bus.o_bus_adr   = adr_q;
    assign bus.o_bus_sel   = sel_q;
    assign bus.o_bus_dat_w = dat_w_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: directed accesses followed by random ones,
// each scored against per-access expectations derived from the rules.
module tb_dbus_ctrl;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dbus_ctrl_if bif ();

    dbus_ctrl #(
        .TIMEOUT (TMO),
        .TW      (8)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif)
    );

    int          total  = 0;
    int          bad    = 0;
    logic [31:0] exp_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bif.i_rd        = 1'b0;
        bif.i_wr        = 1'b0;
        bif.i_addr      = '0;
        bif.i_length    = 2'b00;
        bif.i_we        = '0;
        bif.i_data_wr   = '0;
        bif.i_bus_ack   = 1'b0;
        bif.i_bus_err   = 1'b0;
        bif.i_bus_dat_r = '0;
    endtask

    // Runs one access from a falling edge. The slave answers in BUS
    // cycle number wait_n (0 = first), with err instead of/alongside
    // ack when serr is set; wait_n beyond TMO means it never answers.
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [1:0] len,
                          input logic [3:0] we, input logic [31:0] dat,
                          input int wait_n, input logic serr,
                          input logic [31:0] rdata, input logic hold);
        logic mis;
        logic exp_err;
        int   nbus;
        int   exp_stall;
        int   k;
        int   stall_n;
        int   cyc_n;
        int   done_at;
        mis = (len == 2'b01 && addr[0])
           || (len == 2'b10 && addr[1:0] != 2'b00)
           || (len == 2'b11);
        if (mis) nbus = 0;
        else if (wait_n > TMO) nbus = TMO + 1;
        else nbus = wait_n + 1;
        exp_stall = 1 + nbus;
        exp_err   = mis || (wait_n > TMO) || serr;
        bif.i_rd        = rd;
        bif.i_wr        = wr;
        bif.i_addr      = addr;
        bif.i_length    = len;
        bif.i_we        = we;
        bif.i_data_wr   = dat;
        bif.i_bus_ack   = 1'b0;
        bif.i_bus_err   = 1'b0;
        bif.i_bus_dat_r = rdata;
        k       = 0;
        stall_n = 0;
        cyc_n   = 0;
        done_at = -1;
        for (int t = 0; t < 40; t++) begin
            #1;
            bif.i_bus_ack = 1'b0;
            bif.i_bus_err = 1'b0;
            if (bif.o_done) begin
                done_at = t;
                break;
            end
            if (bif.o_stall) stall_n++;
            if (bif.o_bus_cyc) begin
                cyc_n++;
                chk("adr", bif.o_bus_adr, {addr[31:2], 2'b00});
                chk("we", 32'(bif.o_bus_we), 32'(wr));
                chk("sel", 32'(bif.o_bus_sel), 32'(wr ? we : 4'hF));
                chk("dat_w", bif.o_bus_dat_w, dat);
                if (k == wait_n) begin
                    bif.i_bus_ack = 1'b1;
                    bif.i_bus_err = serr;
                end
                k++;
            end
            @(negedge clk);
        end
        chk("done_latency", 32'(done_at), 32'(exp_stall));
        chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
        chk("cyc_cycles", 32'(cyc_n), 32'(nbus));
        chk("err", 32'(bif.o_err), 32'(exp_err));
        chk("done_stall", 32'(bif.o_stall), 32'd0);
        chk("done_cyc", 32'(bif.o_bus_cyc), 32'd0);
        if (rd && !wr && !exp_err) exp_rd = rdata;
        chk("data_rd", bif.o_data_rd, exp_rd);
        if (!hold) begin
            bif.i_rd = 1'b0;
            bif.i_wr = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic        rd;
        logic        wr;
        logic [31:0] dw;
        idle_in();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cyc", 32'(bif.o_bus_cyc), 32'd0);
        chk("rst_we", 32'(bif.o_bus_we), 32'd0);
        chk("rst_adr", bif.o_bus_adr, 32'd0);
        chk("rst_sel", 32'(bif.o_bus_sel), 32'd0);
        chk("rst_dat_w", bif.o_bus_dat_w, 32'd0);
        chk("rst_data_rd", bif.o_data_rd, 32'd0);
        chk("rst_done", 32'(bif.o_done), 32'd0);
        chk("rst_err", 32'(bif.o_err), 32'd0);
        chk("rst_stall", 32'(bif.o_stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access(1, 0, 32'h0000_1004, 2'b10, 4'h0, 32'h0, 0, 0,
               32'hDEAD_BEEF, 0);
        access(0, 1, 32'h0000_2003, 2'b00, 4'b1000, 32'hAB00_0000, 3, 0,
               32'h1234_5678, 0);
        access(1, 0, 32'h0000_3001, 2'b01, 4'h0, 32'h0, 0, 0,
               32'h5555_5555, 0);
        access(1, 0, 32'h0000_3000, 2'b11, 4'h0, 32'h0, 0, 0,
               32'h6666_6666, 0);
        access(1, 0, 32'h0000_5000, 2'b10, 4'h0, 32'h0, 99, 0,
               32'h7777_7777, 0);
        access(1, 0, 32'h0000_6000, 2'b10, 4'h0, 32'h0, 1, 1,
               32'h9999_9999, 0);
        access(1, 0, 32'h0000_6002, 2'b01, 4'h0, 32'h0, 4, 0,
               32'h0BAD_CAFE, 0);

        bif.i_rd        = 1'b0;
        bif.i_wr        = 1'b1;
        bif.i_addr      = 32'h0000_4000;
        bif.i_length    = 2'b10;
        bif.i_we        = 4'hF;
        bif.i_data_wr   = 32'h1357_9BDF;
        bif.i_bus_ack   = 1'b0;
        bif.i_bus_err   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_cyc", 32'(bif.o_bus_cyc), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(bif.o_bus_cyc), 32'd0);
        chk("arst_we", 32'(bif.o_bus_we), 32'd0);
        chk("arst_sel", 32'(bif.o_bus_sel), 32'd0);
        idle_in();
        @(negedge clk);
        rst = 1'b0;
        exp_rd = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("post_rst_done", 32'(bif.o_done), 32'd0);
            chk("post_rst_cyc", 32'(bif.o_bus_cyc), 32'd0);
            chk("post_rst_stall", 32'(bif.o_stall), 32'd0);
            @(negedge clk);
        end

        access(1, 1, 32'h0000_7000, 2'b10, 4'hF, 32'hCAFE_F00D, 0, 0,
               32'h1111_1111, 1);
        access(1, 1, 32'h0000_7000, 2'b10, 4'hF, 32'hCAFE_F00D, 0, 0,
               32'h1111_1111, 1);
        access(1, 1, 32'h0000_7000, 2'b10, 4'hF, 32'hCAFE_F00D, 2, 0,
               32'h1111_1111, 0);

        for (int n = 0; n < 40; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            dw = $urandom;
            access(rd, wr, $urandom, 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), dw,
                   int'($urandom_range(0, 6)),
                   ($urandom_range(0, 7) == 0),
                   $urandom, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
